// File: rtl/ahb_mem_slave_p.sv
// Single-port AHB memory slave: parametrised width/depth, NONSEQ wait states,
// byte-lane writes, zero-wait SEQ beats, read-after-write forwarding, 2-cycle ERROR.
module ahb_mem_slave_p #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 14,
  parameter int unsigned MEM_WORDS   = 1024,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSELx,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic              HWRITE,
  input  logic [1:0]        TRANS,
  input  logic [2:0]        HSIZE,
  input  logic [2:0]        HBURST,
  input  logic [DATA_W-1:0] HWDATA,
  output logic              HREADY,
  output logic [1:0]        HRESP,
  output logic [DATA_W-1:0] HRDATA
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned LB    = $clog2(NB);
  localparam int unsigned IDX_W = ADDR_W - LB;
  localparam int unsigned MA_W  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_ERR1 = 3'd3;
  localparam logic [2:0] S_ERR2 = 3'd4;

  logic [2:0]        r_state;
  logic [2:0]        r_wcnt;
  logic              r_write;
  logic [MA_W-1:0]   r_addr;
  logic [NB-1:0]     r_be;
  logic [DATA_W-1:0] r_rdata;
  logic [DATA_W-1:0] r_mem [MEM_WORDS];

  logic [2:0]        w_next;
  logic              w_sample;
  logic              w_err;
  logic              w_accept;
  logic              w_fetch;
  logic              w_commit;
  logic [IDX_W-1:0]  w_idx;
  logic [31:0]       w_off;
  logic [NB-1:0]     w_be;
  logic [MA_W-1:0]   w_rd_idx;
  logic [DATA_W-1:0] w_rd_word;
  logic              w_unused;

  assign HREADY   = (r_state != S_WAIT) && (r_state != S_ERR1);
  assign HRESP    = ((r_state == S_ERR1) || (r_state == S_ERR2)) ? 2'b01 : 2'b00;
  assign HRDATA   = r_rdata;
  assign w_unused = ^HBURST;

  assign w_idx    = ADDR[ADDR_W-1:LB];
  assign w_off    = 32'(ADDR) & 32'(NB - 1);
  assign w_sample = HREADY && HSELx && TRANS[1];
  assign w_err    = (32'(w_idx) >= MEM_WORDS) || (32'(HSIZE) > LB) ||
                    ((w_off & ((32'd1 << HSIZE) - 32'd1)) != 32'd0);
  assign w_commit = (r_state == S_DATA) && r_write;
  assign w_rd_idx = (r_state == S_WAIT) ? r_addr : w_idx[MA_W-1:0];

  // Lane b is written when it falls in the same HSIZE-aligned chunk as the address.
  always_comb begin
    w_be = '0;
    for (int unsigned b = 0; b < NB; b++)
      w_be[b] = ((b >> HSIZE) == (w_off >> HSIZE));
  end

  // A write committing on this edge overrides the stale memory bytes it touches.
  always_comb begin
    w_rd_word = r_mem[w_rd_idx];
    if (w_commit && (r_addr == w_rd_idx)) begin
      for (int unsigned b = 0; b < NB; b++)
        if (r_be[b]) w_rd_word[8*b +: 8] = HWDATA[8*b +: 8];
    end
  end

  always_comb begin
    w_next   = S_IDLE;
    w_fetch  = 1'b0;
    w_accept = 1'b0;
    case (r_state)
      S_WAIT: begin
        if (r_wcnt == '0) begin
          w_next  = S_DATA;
          w_fetch = !r_write;
        end else begin
          w_next = S_WAIT;
        end
      end
      S_ERR1: w_next = S_ERR2;
      default: begin
        if (w_sample) begin
          if (w_err) begin
            w_next = S_ERR1;
          end else begin
            w_accept = 1'b1;
            if ((TRANS == 2'b10) && (WAIT_STATES > 0)) begin
              w_next = S_WAIT;
            end else begin
              w_next  = S_DATA;
              w_fetch = !HWRITE;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state <= S_IDLE;
      r_wcnt  <= '0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_be    <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_write <= HWRITE;
        r_addr  <= w_idx[MA_W-1:0];
        r_be    <= w_be;
        r_wcnt  <= 3'(WAIT_STATES - 1);
      end else if ((r_state == S_WAIT) && (r_wcnt != '0)) begin
        r_wcnt <= r_wcnt - 3'd1;
      end
      if (w_fetch) r_rdata <= w_rd_word;
    end
  end

  always_ff @(posedge HCLK) begin
    if (w_commit) begin
      for (int unsigned b = 0; b < NB; b++)
        if (r_be[b]) r_mem[r_addr][8*b +: 8] <= HWDATA[8*b +: 8];
    end
  end

endmodule

// File: tb/tb_ahb_mem_slave_p.sv
// Directed bench for ahb_mem_slave_p: one instance with 2 wait states, one with none.
module tb_ahb_mem_slave_p;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel2, sel0;
  logic [13:0] addr;
  logic        hwrite;
  logic [1:0]  trans;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  logic        rdy2, rdy0;
  logic [1:0]  resp2, resp0;
  logic [31:0] rdata2, rdata0;

  int n_checks = 0;
  int n_err    = 0;
  int          wt;
  logic [31:0] rd;
  logic [1:0]  rs;

  always #5 clk = ~clk;

  ahb_mem_slave_p #(.DATA_W(32), .ADDR_W(14), .MEM_WORDS(1024), .WAIT_STATES(2)) u_dut (
    .HCLK(clk), .HRESETn(rst_n), .HSELx(sel2), .ADDR(addr), .HWRITE(hwrite),
    .TRANS(trans), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata),
    .HREADY(rdy2), .HRESP(resp2), .HRDATA(rdata2)
  );

  ahb_mem_slave_p #(.DATA_W(32), .ADDR_W(14), .MEM_WORDS(1024), .WAIT_STATES(0)) u_dut0 (
    .HCLK(clk), .HRESETn(rst_n), .HSELx(sel0), .ADDR(addr), .HWRITE(hwrite),
    .TRANS(trans), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata),
    .HREADY(rdy0), .HRESP(resp0), .HRDATA(rdata0)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Single NONSEQ transfer; returns HREADY-low cycle count and data-phase HRDATA/HRESP.
  task automatic xfer(input bit use0, input logic [13:0] a, input logic w,
                      input logic [2:0] sz, input logic [31:0] wd,
                      output int waits, output logic [31:0] rdo, output logic [1:0] rso);
    sel2 = !use0; sel0 = use0; addr = a; hwrite = w; trans = 2'b10; hsize = sz; hburst = 3'b000;
    tick;
    sel2 = 1'b0; sel0 = 1'b0; trans = 2'b00; hwdata = wd;
    waits = 0;
    while (!(use0 ? rdy0 : rdy2) && waits < 16) begin
      tick;
      waits++;
    end
    rdo = use0 ? rdata0 : rdata2;
    rso = use0 ? resp0 : resp2;
    tick;
    hwdata = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    sel2 = 1'b0; sel0 = 1'b0; addr = '0; hwrite = 1'b0; trans = 2'b00;
    hsize = 3'd2; hburst = 3'b000; hwdata = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    tick;
    tick;
    check("rst_hready", 32'(rdy2), 32'd1);
    check("rst_hresp", 32'(resp2), 32'd0);
    check("rst_hrdata", rdata2, 32'd0);
    check("rst_hready0", 32'(rdy0), 32'd1);
    rst_n = 1'b1;
    tick;

    // Full-word write then read with two wait states each.
    xfer(0, 14'h0010, 1, 3'd2, 32'hDEADBEEF, wt, rd, rs);
    check("t1_wr_waits", 32'(wt), 32'd2);
    check("t1_wr_resp", 32'(rs), 32'd0);
    xfer(0, 14'h0010, 0, 3'd2, 32'h0, wt, rd, rs);
    check("t1_rd_waits", 32'(wt), 32'd2);
    check("t1_rd_data", rd, 32'hDEADBEEF);
    check("t1_rd_resp", 32'(rs), 32'd0);

    // Byte and half-word lanes.
    xfer(0, 14'h0010, 1, 3'd2, 32'h11223344, wt, rd, rs);
    xfer(0, 14'h0013, 1, 3'd0, 32'hAA998877, wt, rd, rs);
    xfer(0, 14'h0010, 0, 3'd2, 32'h0, wt, rd, rs);
    check("t2_byte_rd", rd, 32'hAA223344);
    xfer(0, 14'h0010, 1, 3'd1, 32'hFFFF5566, wt, rd, rs);
    xfer(0, 14'h0010, 0, 3'd2, 32'h0, wt, rd, rs);
    check("t2_half_rd", rd, 32'hAA225566);

    // INCR4 burst: waits on the first beat only.
    sel2 = 1'b1; addr = 14'h0020; hwrite = 1'b1; trans = 2'b10; hsize = 3'd2; hburst = 3'b011;
    tick;
    addr = 14'h0024; trans = 2'b11; hwdata = 32'hC0DE0000;
    wt = 0;
    while (!rdy2 && wt < 16) begin
      tick;
      wt++;
    end
    check("t3_beat1_waits", 32'(wt), 32'd2);
    tick;
    addr = 14'h0028; hwdata = 32'hC0DE0001;
    check("t3_beat2_ready", 32'(rdy2), 32'd1);
    tick;
    addr = 14'h002C; hwdata = 32'hC0DE0002;
    check("t3_beat3_ready", 32'(rdy2), 32'd1);
    tick;
    sel2 = 1'b0; trans = 2'b00; hburst = 3'b000; hwdata = 32'hC0DE0003;
    check("t3_beat4_ready", 32'(rdy2), 32'd1);
    tick;
    hwdata = '0;
    for (int i = 0; i < 4; i++) begin
      xfer(0, 14'(14'h0020 + 4 * i), 0, 3'd2, 32'h0, wt, rd, rs);
      check($sformatf("t3_rd%0d", i), rd, 32'hC0DE0000 | 32'(i));
    end

    // Zero-wait instance: back-to-back write then read of the same word.
    sel0 = 1'b1; addr = 14'h0040; hwrite = 1'b1; trans = 2'b10; hsize = 3'd2;
    tick;
    check("t4_wr_ready", 32'(rdy0), 32'd1);
    hwrite = 1'b0; hwdata = 32'h12345678;
    tick;
    check("t4_fwd_data", rdata0, 32'h12345678);
    check("t4_fwd_ready", 32'(rdy0), 32'd1);
    sel0 = 1'b0; trans = 2'b00;
    tick;
    xfer(1, 14'h0044, 1, 3'd2, 32'hCAFEF00D, wt, rd, rs);
    check("t4_ws0_waits", 32'(wt), 32'd0);
    sel0 = 1'b1; addr = 14'h0045; hwrite = 1'b1; trans = 2'b10; hsize = 3'd0;
    tick;
    addr = 14'h0044; hwrite = 1'b0; hsize = 3'd2; hwdata = 32'h99887766;
    tick;
    check("t4_fwd_byte", rdata0, 32'hCAFE770D);
    sel0 = 1'b0; trans = 2'b00;
    tick;
    xfer(1, 14'h0040, 0, 3'd2, 32'h0, wt, rd, rs);
    check("t4_mem_rd", rd, 32'h12345678);

    // Error responses.
    sel2 = 1'b1; addr = 14'h1000; hwrite = 1'b0; trans = 2'b10; hsize = 3'd2;
    tick;
    sel2 = 1'b0; trans = 2'b00;
    check("t5_err1_ready", 32'(rdy2), 32'd0);
    check("t5_err1_resp", 32'(resp2), 32'd1);
    tick;
    check("t5_err2_ready", 32'(rdy2), 32'd1);
    check("t5_err2_resp", 32'(resp2), 32'd1);
    tick;
    check("t5_after_resp", 32'(resp2), 32'd0);
    xfer(0, 14'h0FFC, 1, 3'd2, 32'h600DCAFE, wt, rd, rs);
    check("t5_last_word_resp", 32'(rs), 32'd0);
    xfer(0, 14'h0FFC, 0, 3'd2, 32'h0, wt, rd, rs);
    check("t5_last_word_rd", rd, 32'h600DCAFE);
    xfer(0, 14'h0000, 1, 3'd2, 32'h0BADF00D, wt, rd, rs);
    xfer(0, 14'h0002, 1, 3'd2, 32'hFFFFFFFF, wt, rd, rs);
    check("t5_misal_word_waits", 32'(wt), 32'd1);
    check("t5_misal_word_resp", 32'(rs), 32'd1);
    xfer(0, 14'h0001, 1, 3'd1, 32'hFFFFFFFF, wt, rd, rs);
    check("t5_misal_half_resp", 32'(rs), 32'd1);
    xfer(0, 14'h0000, 1, 3'd3, 32'hFFFFFFFF, wt, rd, rs);
    check("t5_oversize_resp", 32'(rs), 32'd1);
    xfer(0, 14'h0000, 0, 3'd2, 32'h0, wt, rd, rs);
    check("t5_mem_unchanged", rd, 32'h0BADF00D);

    // Reset in the middle of a write's wait states.
    xfer(0, 14'h0050, 1, 3'd2, 32'h5A5A5A5A, wt, rd, rs);
    xfer(0, 14'h0050, 0, 3'd2, 32'h0, wt, rd, rs);
    check("t6_pre_rd", rd, 32'h5A5A5A5A);
    sel2 = 1'b1; addr = 14'h0050; hwrite = 1'b1; trans = 2'b10; hsize = 3'd2;
    tick;
    sel2 = 1'b0; trans = 2'b00; hwdata = 32'h11111111;
    check("t6_in_wait", 32'(rdy2), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_ready", 32'(rdy2), 32'd1);
    check("t6_rst_resp", 32'(resp2), 32'd0);
    check("t6_rst_rdata", rdata2, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    hwdata = '0;
    tick;
    xfer(0, 14'h0050, 0, 3'd2, 32'h0, wt, rd, rs);
    check("t6_post_waits", 32'(wt), 32'd2);
    check("t6_post_rd", rd, 32'h5A5A5A5A);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
